// File: rtl/mem_block_mover.sv
// mem_block_mover: copies or fills a block of memory words through the single data memory port.
module mem_block_mover #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_mode,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic [DATA_WIDTH-1:0] i_fill_data,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_wr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH:0]   r_rem;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [ADDR_WIDTH-1:0] w_index;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (i_len == '0) ? S_DONE : (i_mode ? S_WRITE : S_READ);
            S_READ:  w_next = i_abort ? S_IDLE : S_WRITE;
            S_WRITE: w_next = i_abort ? S_IDLE :
                              (r_rem == (ADDR_WIDTH+1)'(1)) ? S_DONE :
                              (r_mode ? S_WRITE : S_READ);
            default: w_next = S_IDLE;
        endcase
    end
    // Pointers wrap naturally at ADDR_WIDTH bits; the write edge always commits, even on abort.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_rem  <= '0;
            r_mode <= 1'b0;
            r_fill <= '0;
            r_buf  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_src  <= i_src_addr;
                    r_dst  <= i_dst_addr;
                    r_rem  <= i_len;
                    r_mode <= i_mode;
                    r_fill <= i_fill_data;
                end
                S_READ:  r_buf <= i_mem_rdata;
                S_WRITE: begin
                    r_src <= r_src + ADDR_WIDTH'(1);
                    r_dst <= r_dst + ADDR_WIDTH'(1);
                    r_rem <= r_rem - (ADDR_WIDTH+1)'(1);
                end
                default: ;
            endcase
        end
    end
    always_comb begin
        o_busy      = (r_state == S_READ) || (r_state == S_WRITE);
        o_done      = r_state == S_DONE;
        o_mem_wr    = r_state == S_WRITE;
        w_index     = (r_state == S_WRITE) ? r_dst : (r_state == S_READ) ? r_src : '0;
        o_mem_addr  = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_index};
        o_mem_wdata = (r_state == S_WRITE) ? (r_mode ? r_fill : r_buf) : '0;
    end
endmodule

// File: tb/tb_mem_block_mover.sv
// tb_mem_block_mover: randomized and directed checks against a transaction-level model of the mover.
module tb_mem_block_mover;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_mode = 1'b0;
    logic        i_abort = 1'b0;
    logic [6:0]  i_src_addr = '0;
    logic [6:0]  i_dst_addr = '0;
    logic [7:0]  i_len = '0;
    logic [31:0] i_fill_data = '0;
    logic        o_busy, o_done, o_mem_wr;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [31:0] mem [128];
    logic [31:0] ref_mem [128];
    logic        bd_we = 1'b0;
    logic [6:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_cnt = 0;

    typedef struct {
        int          kind;
        logic        cp;
        logic [6:0]  a;
        logic [31:0] d;
    } op_t;
    op_t         q[$];
    op_t         cur;
    logic [31:0] buf_m;
    logic [31:0] wv;

    mem_block_mover dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
        .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_len(i_len),
        .i_fill_data(i_fill_data), .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wr(o_mem_wr),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;
    assign i_mem_rdata = mem[o_mem_addr[6:0]];

    always @(posedge i_clk) begin
        if (o_mem_wr) mem[o_mem_addr[6:0]] <= o_mem_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
        if (o_mem_wr) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 30) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input int k, input logic c, input logic [6:0] a, input logic [31:0] d);
        op_t o;
        o.kind = k;
        o.cp = c;
        o.a = a;
        o.d = d;
        return o;
    endfunction

    // Model: a start seen while idle expands into the full list of bus cycles; each cycle pops one.
    always @(negedge i_clk) begin
        if (i_rst) begin
            chk("rst_busy", 32'(o_busy), 0);
            chk("rst_done", 32'(o_done), 0);
            chk("rst_wr", 32'(o_mem_wr), 0);
            chk("rst_addr", o_mem_addr, 0);
            chk("rst_wdata", o_mem_wdata, 0);
            q.delete();
        end else if (q.size() == 0) begin
            chk("idle_busy", 32'(o_busy), 0);
            chk("idle_done", 32'(o_done), 0);
            chk("idle_wr", 32'(o_mem_wr), 0);
            if (bd_we) ref_mem[bd_addr] = bd_data;
            if (i_start) begin
                for (int k = 0; k < int'(i_len); k++) begin
                    if (!i_mode) q.push_back(mk(0, 1'b0, 7'(int'(i_src_addr) + k), 32'h0));
                    q.push_back(mk(1, !i_mode, 7'(int'(i_dst_addr) + k), i_fill_data));
                end
                q.push_back(mk(2, 1'b0, 7'h0, 32'h0));
            end
        end else begin
            cur = q.pop_front();
            if (cur.kind == 0) begin
                chk("rd_busy", 32'(o_busy), 1);
                chk("rd_wr", 32'(o_mem_wr), 0);
                chk("rd_done", 32'(o_done), 0);
                chk("rd_addr", o_mem_addr, {25'b0, cur.a});
                buf_m = ref_mem[cur.a];
            end else if (cur.kind == 1) begin
                wv = cur.cp ? buf_m : cur.d;
                chk("wr_busy", 32'(o_busy), 1);
                chk("wr_wr", 32'(o_mem_wr), 1);
                chk("wr_done", 32'(o_done), 0);
                chk("wr_addr", o_mem_addr, {25'b0, cur.a});
                chk("wr_data", o_mem_wdata, wv);
                ref_mem[cur.a] = wv;
            end else begin
                chk("dn_busy", 32'(o_busy), 0);
                chk("dn_done", 32'(o_done), 1);
                chk("dn_wr", 32'(o_mem_wr), 0);
            end
            if (i_abort && cur.kind != 2) q.delete();
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic poke(input logic [6:0] a, input logic [31:0] d);
        bd_we = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic start_xfer(input logic m, input logic [6:0] s, input logic [6:0] d,
                              input logic [7:0] l, input logic [31:0] f, input logic ab);
        i_mode = m;
        i_src_addr = s;
        i_dst_addr = d;
        i_len = l;
        i_fill_data = f;
        i_abort = ab;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        i_mode = 1'($urandom);
        i_src_addr = 7'($urandom);
        i_dst_addr = 7'($urandom);
        i_len = 8'($urandom);
        i_fill_data = $urandom;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 1;
        while (!o_done && lat <= budget) begin
            tick();
            lat++;
        end
        n_checks++;
        if (!o_done) begin
            n_errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done within %0d", lat, budget);
        end
        tick();
    endtask

    task automatic mem_check(input string nm);
        int bad = -1;
        for (int i = 0; i < 128; i++)
            if (mem[i] !== ref_mem[i] && bad < 0) bad = i;
        chk(nm, 32'(bad), 32'hFFFF_FFFF);
    endtask

    task automatic run_random(input bit ab_en);
        int          n = 0;
        logic [7:0]  l;
        l = ($urandom % 12 == 0) ? 8'd128 : 8'($urandom % 20);
        start_xfer(1'($urandom), 7'($urandom), 7'($urandom), l, $urandom, ($urandom % 4) == 0);
        while ((o_busy || o_done) && n < 300) begin
            i_start = ($urandom % 6) == 0;
            i_mode = 1'($urandom);
            i_src_addr = 7'($urandom);
            i_dst_addr = 7'($urandom);
            i_len = 8'($urandom % 9);
            i_fill_data = $urandom;
            i_abort = ab_en && ($urandom % 30 == 0);
            tick();
            n++;
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        n_checks++;
        if (n >= 300) begin
            n_errors++;
            $display("FAIL rand_timeout: got busy after %0d cycles, required idle within 300", n);
        end
        mem_check("rand_mem");
    endtask

    initial begin
        int lat;
        int w0;
        tick();
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 128; i++) poke(7'(i), $urandom);

        // Copy of four words
        poke(7'd10, 32'hA0A0_0001); poke(7'd11, 32'hB0B0_0002);
        poke(7'd12, 32'hC0C0_0003); poke(7'd13, 32'hD0D0_0004);
        for (int i = 40; i < 44; i++) poke(7'(i), 32'h0);
        start_xfer(1'b0, 7'd10, 7'd40, 8'd4, 32'h0, 1'b0);
        wait_done(50, lat);
        chk("copy_lat", 32'(lat), 9);
        chk("copy_w0", mem[40], 32'hA0A0_0001);
        chk("copy_w1", mem[41], 32'hB0B0_0002);
        chk("copy_w2", mem[42], 32'hC0C0_0003);
        chk("copy_w3", mem[43], 32'hD0D0_0004);
        mem_check("copy_mem");

        // Fill wrapping past the top of memory
        start_xfer(1'b1, 7'd0, 7'd126, 8'd4, 32'hDEAD_BEEF, 1'b0);
        wait_done(50, lat);
        chk("fill_lat", 32'(lat), 5);
        chk("fill_126", mem[126], 32'hDEAD_BEEF);
        chk("fill_127", mem[127], 32'hDEAD_BEEF);
        chk("fill_0", mem[0], 32'hDEAD_BEEF);
        chk("fill_1", mem[1], 32'hDEAD_BEEF);
        mem_check("fill_mem");

        // Zero length, then a second start during a copy
        w0 = wr_cnt;
        start_xfer(1'b0, 7'd5, 7'd6, 8'd0, 32'h0, 1'b0);
        wait_done(10, lat);
        chk("len0_lat", 32'(lat), 1);
        chk("len0_writes", 32'(wr_cnt - w0), 0);
        w0 = wr_cnt;
        start_xfer(1'b0, 7'd20, 7'd70, 8'd5, 32'h0, 1'b0);
        tick();
        i_start = 1'b1; i_mode = 1'b1; i_dst_addr = 7'd90; i_len = 8'd3;
        tick();
        i_start = 1'b0;
        wait_done(60, lat);
        chk("busy_start_lat", 32'(lat + 2), 11);
        chk("busy_start_writes", 32'(wr_cnt - w0), 5);
        mem_check("busy_start_mem");

        // Overlapping copy smears the first word
        poke(7'd0, 32'd1); poke(7'd1, 32'd2); poke(7'd2, 32'd3); poke(7'd3, 32'd4);
        start_xfer(1'b0, 7'd0, 7'd1, 8'd3, 32'h0, 1'b0);
        wait_done(50, lat);
        chk("ovl_1", mem[1], 32'd1);
        chk("ovl_2", mem[2], 32'd1);
        chk("ovl_3", mem[3], 32'd1);
        mem_check("ovl_mem");

        // Abort in the write of word 2
        for (int i = 0; i < 6; i++) begin poke(7'(30 + i), 32'(100 + i)); poke(7'(50 + i), 32'h0); end
        start_xfer(1'b0, 7'd30, 7'd50, 8'd6, 32'h0, 1'b0);
        repeat (5) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_idle", 32'(o_busy), 0);
        for (int i = 0; i < 10; i++) begin chk("abort_nodone", 32'(o_done), 0); tick(); end
        for (int i = 0; i < 3; i++) chk("abort_written", mem[50 + i], 32'(100 + i));
        for (int i = 3; i < 6; i++) chk("abort_untouched", mem[50 + i], 32'h0);
        mem_check("abort_mem");

        // Reset while word 3 of an 8-word fill is on the bus
        for (int i = 60; i < 68; i++) poke(7'(i), 32'h0);
        start_xfer(1'b1, 7'd0, 7'd60, 8'd8, 32'h5A5A_5A5A, 1'b0);
        repeat (3) tick();
        i_rst = 1'b1;
        #1;
        chk("rst_mid_wr", 32'(o_mem_wr), 0);
        chk("rst_mid_busy", 32'(o_busy), 0);
        tick();
        i_rst = 1'b0;
        for (int i = 60; i < 63; i++) chk("rst_written", mem[i], 32'h5A5A_5A5A);
        for (int i = 63; i < 68; i++) chk("rst_untouched", mem[i], 32'h0);
        mem_check("rst_mem");
        tick();

        for (int t = 0; t < 40; t++) run_random(t % 2 == 1);
        mem_check("final_mem");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
